// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 keystream generator.
//   rc4_state_e : controller states
//   SBOX_SIZE   : number of S-box entries
//   KEY_BUS_W   : width of the zero-extended key bus used by key_byte()
//   key_byte()  : extracts byte idx from a packed key bus (byte k = bits [8k+7:8k])
package rc4_pkg;

  localparam int unsigned SBOX_SIZE = 256;
  localparam int unsigned KEY_BUS_W = SBOX_SIZE * 8;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StKsa,
    StDrop,
    StPrga
  } rc4_state_e;

  function automatic logic [7:0] key_byte(input logic [KEY_BUS_W-1:0] key,
                                          input logic [7:0]           idx);
    return key[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/rc4_sbox.sv
// 256 x 8 RC4 S-box held in flops.
//   addr_a/rdata_a, addr_b/rdata_b, addr_t/rdata_t : combinational read ports
//   we_a/waddr_a/wdata_a, we_b/waddr_b/wdata_b       : write ports (same-cycle swap)
// When both write ports target the same entry, that entry keeps its value.
module rc4_sbox
  import rc4_pkg::*;
(
  input  logic       clk,
  input  logic [7:0] addr_a,
  input  logic [7:0] addr_b,
  input  logic [7:0] addr_t,
  output logic [7:0] rdata_a,
  output logic [7:0] rdata_b,
  output logic [7:0] rdata_t,
  input  logic       we_a,
  input  logic [7:0] waddr_a,
  input  logic [7:0] wdata_a,
  input  logic       we_b,
  input  logic [7:0] waddr_b,
  input  logic [7:0] wdata_b
);

  logic [7:0] mem [SBOX_SIZE];
  logic       same_addr;

  assign rdata_a   = mem[addr_a];
  assign rdata_b   = mem[addr_b];
  assign rdata_t   = mem[addr_t];
  assign same_addr = we_a && we_b && (waddr_a == waddr_b);

  always_ff @(posedge clk) begin
    for (int k = 0; k < SBOX_SIZE; k++) begin
      if (!same_addr) begin
        if (we_a && (waddr_a == 8'(k))) begin
          mem[k] <= wdata_a;
        end else if (we_b && (waddr_b == 8'(k))) begin
          mem[k] <= wdata_b;
        end
      end
    end
  end

endmodule

// File: rtl/rc4_stream_gen.sv
// RC4 keystream generator with configurable key length and RC4-drop[N].
//   clk, rst            : clock, synchronous active-high reset
//   start, stop         : begin (IDLE only) / return to IDLE from any state
//   key, key_length     : packed key bytes and length in bytes (1..MAX_KEY_BYTES)
//   drop_len            : initial keystream bytes to discard
//   ks_data, ks_valid   : keystream byte and its valid flag
//   ks_ready            : consumer accepts ks_data
//   busy, err           : not-idle flag, one-cycle pulse on a rejected start
module rc4_stream_gen
  import rc4_pkg::*;
#(
  parameter int unsigned MAX_KEY_BYTES = 16,
  parameter int unsigned DROP_W        = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       stop,
  input  logic [MAX_KEY_BYTES*8-1:0] key,
  input  logic [8:0]                 key_length,
  input  logic [DROP_W-1:0]          drop_len,
  output logic [7:0]                 ks_data,
  output logic                       ks_valid,
  input  logic                       ks_ready,
  output logic                       busy,
  output logic                       err
);

  localparam logic [8:0] MaxLen = 9'(MAX_KEY_BYTES);

  rc4_state_e                 state;
  logic [7:0]                 i, j, kidx, klen_last;
  logic [DROP_W-1:0]          drop_cnt, drop_reg;
  logic [MAX_KEY_BYTES*8-1:0] key_reg;
  logic [KEY_BUS_W-1:0]       key_bus;

  logic [7:0] addr_a, addr_t, si, sj, st, kbyte, j_ksa, j_prga, j_new, ks_byte;
  logic       we_a, we_b;
  logic [7:0] waddr_a, wdata_a;
  logic       len_bad, start_ok, step;

  assign key_bus = KEY_BUS_W'(key_reg);
  assign len_bad = (key_length == 9'd0) || (key_length > MaxLen);
  assign start_ok = start && !stop && (state == StIdle) && !len_bad;

  always_comb begin
    // KSA indexes S[i]; PRGA/DROP indexes S[i+1].
    addr_a  = (state == StKsa) ? i : i + 8'd1;
    kbyte   = key_byte(key_bus, kidx);
    j_ksa   = j + si + kbyte;
    j_prga  = j + si;
    j_new   = (state == StKsa) ? j_ksa : j_prga;
    addr_t  = si + sj;
    // S[t] must reflect the swap that happens on this same edge.
    if (addr_t == addr_a) begin
      ks_byte = sj;
    end else if (addr_t == j_new) begin
      ks_byte = si;
    end else begin
      ks_byte = st;
    end
    step = !stop && ((state == StDrop) || ((state == StPrga) && (!ks_valid || ks_ready)));

    we_a    = 1'b0;
    we_b    = 1'b0;
    waddr_a = addr_a;
    wdata_a = sj;
    if (!stop) begin
      unique case (state)
        StIdle: begin
          // The accept cycle performs the S[0]=0 write, keeping INIT at 256 writes
          // while the first byte lands 512 cycles after acceptance.
          if (start_ok) begin
            we_a    = 1'b1;
            waddr_a = 8'd0;
            wdata_a = 8'd0;
          end
        end
        StInit: begin
          we_a    = 1'b1;
          waddr_a = i;
          wdata_a = i;
        end
        StKsa: begin
          we_a = 1'b1;
          we_b = 1'b1;
        end
        StDrop, StPrga: begin
          we_a = step;
          we_b = step;
        end
        default: ;
      endcase
    end
  end

  rc4_sbox u_sbox (
    .clk     (clk),
    .addr_a  (addr_a),
    .addr_b  (j_new),
    .addr_t  (addr_t),
    .rdata_a (si),
    .rdata_b (sj),
    .rdata_t (st),
    .we_a    (we_a),
    .waddr_a (waddr_a),
    .wdata_a (wdata_a),
    .we_b    (we_b),
    .waddr_b (j_new),
    .wdata_b (si)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      i         <= 8'd0;
      j         <= 8'd0;
      kidx      <= 8'd0;
      klen_last <= 8'd0;
      drop_cnt  <= '0;
      drop_reg  <= '0;
      key_reg   <= '0;
      ks_data   <= 8'd0;
      ks_valid  <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      if (stop) begin
        state    <= StIdle;
        ks_valid <= 1'b0;
        busy     <= 1'b0;
      end else begin
        unique case (state)
          StIdle: begin
            if (start) begin
              if (len_bad) begin
                err <= 1'b1;
              end else begin
                key_reg   <= key;
                klen_last <= 8'(key_length - 9'd1);
                drop_reg  <= drop_len;
                i         <= 8'd1;
                j         <= 8'd0;
                kidx      <= 8'd0;
                busy      <= 1'b1;
                state     <= StInit;
              end
            end
          end
          StInit: begin
            i <= i + 8'd1;
            if (i == 8'hFF) begin
              state <= StKsa;
            end
          end
          StKsa: begin
            i    <= i + 8'd1;
            j    <= j_ksa;
            kidx <= (kidx == klen_last) ? 8'd0 : kidx + 8'd1;
            if (i == 8'hFF) begin
              j <= 8'd0;
              if (drop_reg == '0) begin
                state <= StPrga;
              end else begin
                drop_cnt <= drop_reg;
                state    <= StDrop;
              end
            end
          end
          StDrop: begin
            i        <= addr_a;
            j        <= j_prga;
            drop_cnt <= drop_cnt - 1'b1;
            if (drop_cnt == DROP_W'(1)) begin
              state <= StPrga;
            end
          end
          StPrga: begin
            if (step) begin
              i        <= addr_a;
              j        <= j_prga;
              ks_data  <= ks_byte;
              ks_valid <= 1'b1;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule
